// File: rtl/ascon_host_bridge_if.sv
// Host-facing job and word-stream bundle of the Ascon host bridge.
// Handshakes: a word moves on any cycle where valid and ready are both high at the rising edge.
interface ascon_host_bridge_if #(
    parameter int DATA_AW = 7,
    parameter int TAG_W   = 128
);
    logic               job_valid;
    logic [DATA_AW-1:0] ad_size;
    logic [DATA_AW-1:0] pt_size;
    logic [TAG_W-1:0]   exp_tag;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;

    modport master (
        output job_valid, ad_size, pt_size, exp_tag, abort,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  job_valid, ad_size, pt_size, exp_tag, abort,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ascon_host_bridge.sv
// Host bridge for the Ascon AEAD core: loads AD/PT FIFOs from the host stream,
// starts the core, drains CT back to the host and checks the produced tag.
module ascon_host_bridge #(
    parameter int DATA_AW = 7,
    parameter int TAG_W   = 128
) (
    input  logic                clk,
    input  logic                rst,
    ascon_host_bridge_if.slave  host,
    output logic                ad_push_o,
    output logic [63:0]         ad_data_o,
    input  logic                ad_full_i,
    output logic                pt_push_o,
    output logic [63:0]         pt_data_o,
    input  logic                pt_full_i,
    output logic                ct_pop_o,
    input  logic [63:0]         ct_i,
    input  logic                ct_empty_i,
    input  logic                core_ready_i,
    output logic                core_start_o,
    input  logic                tag_valid_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                flush_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                tag_match_o,
    output logic [2:0]          state_o
);
    localparam int CW = DATA_AW - 2;

    typedef enum logic [2:0] {
        IDLE, LOAD_AD, LOAD_PT, START, DRAIN, WAIT_TAG, DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    ad_cnt;
    logic [CW-1:0]    pt_cnt;
    logic [CW-1:0]    ct_cnt;
    logic [TAG_W-1:0] exp_tag;
    logic             tag_seen;
    logic [CW-1:0]    nad;
    logic [CW-1:0]    npt;
    logic             ct_fire;
    logic             tag_window;

    // Byte size rounded up to whole 64-bit words.
    assign nad = CW'(host.ad_size[DATA_AW-1:3]) + CW'(|host.ad_size[2:0]);
    assign npt = CW'(host.pt_size[DATA_AW-1:3]) + CW'(|host.pt_size[2:0]);

    assign host.in_ready  = (state == LOAD_AD && !ad_full_i) || (state == LOAD_PT && !pt_full_i);
    assign ad_push_o      = (state == LOAD_AD) && host.in_valid && !ad_full_i;
    assign pt_push_o      = (state == LOAD_PT) && host.in_valid && !pt_full_i;
    assign ad_data_o      = (state == LOAD_AD) ? host.in_data : '0;
    assign pt_data_o      = (state == LOAD_PT) ? host.in_data : '0;
    assign host.out_valid = (state == DRAIN) && !ct_empty_i;
    assign host.out_data  = (state == DRAIN) ? ct_i : '0;
    assign ct_fire        = host.out_valid && host.out_ready;
    assign ct_pop_o       = ct_fire;
    // An abort in START must not launch the core it is about to cancel.
    assign core_start_o   = (state == START) && core_ready_i && !host.abort;
    assign tag_window     = (state == START) || (state == DRAIN) || (state == WAIT_TAG);
    assign state_o        = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ad_cnt      <= '0;
            pt_cnt      <= '0;
            ct_cnt      <= '0;
            exp_tag     <= '0;
            tag_seen    <= 1'b0;
            flush_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            tag_o       <= '0;
            tag_match_o <= 1'b0;
        end else begin
            flush_o <= 1'b0;
            done_o  <= 1'b0;
            if (state != IDLE && host.abort) begin
                state    <= IDLE;
                flush_o  <= 1'b1;
                busy_o   <= 1'b0;
                tag_seen <= 1'b0;
            end else begin
                // The tag may land while CT is still draining; hold it until WAIT_TAG.
                if (tag_window && tag_valid_i) begin
                    tag_o       <= tag_i;
                    tag_seen    <= 1'b1;
                    tag_match_o <= (tag_i == exp_tag);
                end
                unique case (state)
                    IDLE: begin
                        if (host.job_valid) begin
                            ad_cnt      <= nad;
                            pt_cnt      <= npt;
                            ct_cnt      <= npt;
                            exp_tag     <= host.exp_tag;
                            tag_seen    <= 1'b0;
                            tag_match_o <= 1'b0;
                            busy_o      <= 1'b1;
                            if (nad != '0)      state <= LOAD_AD;
                            else if (npt != '0) state <= LOAD_PT;
                            else                state <= START;
                        end
                    end
                    LOAD_AD: begin
                        if (ad_push_o) begin
                            ad_cnt <= ad_cnt - CW'(1);
                            if (ad_cnt == CW'(1)) state <= (pt_cnt != '0) ? LOAD_PT : START;
                        end
                    end
                    LOAD_PT: begin
                        if (pt_push_o) begin
                            pt_cnt <= pt_cnt - CW'(1);
                            if (pt_cnt == CW'(1)) state <= START;
                        end
                    end
                    START: begin
                        if (core_ready_i) state <= (ct_cnt != '0) ? DRAIN : WAIT_TAG;
                    end
                    DRAIN: begin
                        if (ct_fire) begin
                            ct_cnt <= ct_cnt - CW'(1);
                            if (ct_cnt == CW'(1)) state <= WAIT_TAG;
                        end
                    end
                    WAIT_TAG: begin
                        if (tag_seen) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ascon_host_bridge.md
Name: ascon_host_bridge

Overview:
- Host-side counterpart of the Ascon AEAD core's FIFO interface.
- Accepts one job configuration and a valid/ready stream of 64-bit words from the host.
- Routes the words into the AD and PT FIFOs, then starts the core.
- Drains ciphertext words from the CT FIFO to the host, captures the final tag, and reports the job result against an expected tag.

Parameters:
- DATA_AW, 7: width of the byte-size fields. Word counters are DATA_AW-2 bits.
- TAG_W, 128: tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- job_valid_i  in  1  job request; accepted only in IDLE
- ad_size_i  in  DATA_AW  AD length in bytes
- pt_size_i  in  DATA_AW  PT length in bytes
- exp_tag_i  in  TAG_W  expected tag; sampled at job accept
- abort_i  in  1  cancel the current job
- in_valid_i / in_ready_o  in/out  1  host input handshake
- in_data_i  in  64  host word
- out_valid_o / out_ready_i  out/in  1  host output handshake
- out_data_o  out  64  CT word
- ad_push_o  out  1  AD FIFO push
- ad_data_o  out  64  AD FIFO data
- ad_full_i  in  1  AD FIFO full
- pt_push_o  out  1  PT FIFO push
- pt_data_o  out  64  PT FIFO data
- pt_full_i  in  1  PT FIFO full
- ct_pop_o  out  1  CT FIFO pop
- ct_i  in  64  CT FIFO data (first-word fall-through)
- ct_empty_i  in  1  CT FIFO empty
- core_ready_i  in  1  core idle
- core_start_o  out  1  core start pulse
- tag_valid_i  in  1  core tag valid pulse
- tag_i  in  TAG_W  core tag
- flush_o  out  1  one-cycle flush to all three FIFOs
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- tag_o  out  TAG_W  captured tag
- tag_match_o  out  1  captured tag equals expected tag; valid from done_o until the next job accept

Behaviour:
- Reset (registered outputs): all go to 0; state goes to IDLE.
- Word counts at accept:
  - nad = (ad_size_i+7)>>3
  - npt = (pt_size_i+7)>>3
  - Both are held in DATA_AW-2-bit down-counters.
- States and transitions:
  - IDLE: on job_valid_i, latch nad, npt and exp_tag_i; clear tag_seen; busy_o=1. Go to LOAD_AD if nad≠0, else LOAD_PT if npt≠0, else START.
  - LOAD_AD:
    - in_ready_o = !ad_full_i.
    - ad_push_o = in_valid_i & in_ready_o; ad_data_o = in_data_i (combinational).
    - Each push decrements the AD count. The last push goes to LOAD_PT, or to START if npt=0.
  - LOAD_PT: same as LOAD_AD using the PT FIFO and PT count. The last push goes to START.
  - START: wait for core_ready_i. core_start_o is high for exactly 1 cycle, combinational with the exit. Next state is DRAIN if npt≠0, else WAIT_TAG.
  - DRAIN:
    - out_valid_o = !ct_empty_i; out_data_o = ct_i.
    - ct_pop_o = out_valid_o & out_ready_i.
    - Each pop decrements the CT count; the last pop goes to WAIT_TAG.
  - WAIT_TAG: when tag_seen is set, go to DONE.
  - DONE: done_o=1 for 1 cycle; busy_o drops; go to IDLE.
- Tag capture:
  - Active in START, DRAIN and WAIT_TAG.
  - tag_valid_i latches tag_i into tag_o, sets tag_seen, and registers tag_match_o = (tag_i==exp_tag).
  - A tag arriving during DRAIN is held; the drain continues.
  - If tag_seen is already set and the transition into WAIT_TAG happens that cycle, DONE follows on the next cycle.
- Backpressure:
  - in_ready_o=0 outside the LOAD states.
  - out_valid_o=0 outside DRAIN.
  - A full or empty FIFO stalls with no data loss; counts are unchanged while stalled.
- Abort: abort_i in any non-IDLE state has priority over all transitions. Next cycle: state IDLE, flush_o=1 for 1 cycle, busy_o=0, no done_o. abort_i in IDLE is ignored.
- Ignored inputs:
  - job_valid_i outside IDLE.
  - tag_valid_i in IDLE, LOAD_AD and LOAD_PT.
- Reset mid-job returns to IDLE with all outputs at 0. The FIFOs are not flushed by reset.

Test Plan:
1. Job ad_size=16, pt_size=20, in_valid held high, FIFOs never full -> ad_push on 2 cycles, pt_push on 3 cycles, one core_start pulse. Host receives 3 CT words in FIFO order. tag_valid with tag_i==exp_tag gives done_o pulse and tag_match_o=1.
2. Job ad_size=0, pt_size=0 -> IDLE→START directly, no pushes, no pops. done_o follows tag_valid; tag mismatch gives tag_match_o=0 and tag_o = core value.
3. pt_size=9 with pt_full_i toggling every other cycle and out_ready_i low for 5 cycles mid-drain -> exactly 2 pushes and 2 pops, no duplicated or dropped words, counts unchanged during stalls.
4. tag_valid_i asserted while 1 CT word remains undrained -> tag held, drain completes, done_o occurs exactly 1 cycle after WAIT_TAG is entered.
5. abort_i during LOAD_PT after 1 of 3 words -> flush_o pulses once, busy_o=0, no core_start_o, no done_o; a new job is accepted the following cycle.
6. rst asserted during DRAIN -> next cycle all outputs 0 and state IDLE. job_valid_i during a busy job is ignored.
